// File: rtl/count_sequencer.sv
// count_sequencer: control FSM for an external up-counter.
// Captures start/limit/mode on an accepted start, loads the counter, gates
// its increment enable from step pulses (manual) or a prescaler tick (auto),
// and stops at the programmed limit.
// Build option: define COUNT_SEQ_WRAP_EN to reload and keep running at the
// limit instead of stopping, counting completed laps on the laps output.
module count_sequencer #(
    parameter int N        = 6,
    parameter int TICK_DIV = 50000000
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic         stop,
    input  logic         mode,
    input  logic         step,
    input  logic [N-1:0] init_value,
    input  logic [N-1:0] limit,
    input  logic [N-1:0] count,
    output logic         cnt_load,
    output logic [N-1:0] load_value,
    output logic         cnt_en,
    output logic         busy,
    output logic         done,
    output logic [1:0]   state,
    output logic [7:0]   laps
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        LOAD = 2'b01,
        RUN  = 2'b10,
        DONE = 2'b11
    } state_t;

    state_t        state_reg, state_next;
    logic [N-1:0]  load_value_reg;
    logic [N-1:0]  limit_reg;
    logic          mode_reg;
    logic [PW-1:0] presc_reg, presc_next;
    logic          capture;
    logic          terminal;

    // Equality-only compare: an init above the limit simply wraps through 0.
    assign terminal = (count == limit_reg);

    // Next-state, increment enable and prescaler update.
    always_comb begin
        state_next = state_reg;
        presc_next = presc_reg;
        cnt_en     = 1'b0;
        capture    = 1'b0;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    capture    = 1'b1;
                    state_next = LOAD;
                end
            end
            LOAD: begin
                presc_next = '0;
                state_next = stop ? IDLE : RUN;
            end
            RUN: begin
                if (stop) begin
                    state_next = IDLE;
                end else if (terminal) begin
`ifdef COUNT_SEQ_WRAP_EN
                    state_next = LOAD;
`else
                    state_next = DONE;
`endif
                end else if (mode_reg) begin
                    if (presc_reg == PRESC_LAST) begin
                        cnt_en     = 1'b1;
                        presc_next = '0;
                    end else begin
                        presc_next = presc_reg + 1'b1;
                    end
                end else begin
                    cnt_en = step;
                end
            end
            DONE: begin
                if (stop) begin
                    state_next = IDLE;
                end else if (start) begin
                    capture    = 1'b1;
                    state_next = LOAD;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // State, captured run parameters and prescaler.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg      <= IDLE;
            load_value_reg <= '0;
            limit_reg      <= '0;
            mode_reg       <= 1'b0;
            presc_reg      <= '0;
        end else begin
            state_reg <= state_next;
            presc_reg <= presc_next;
            if (capture) begin
                load_value_reg <= init_value;
                limit_reg      <= limit;
                mode_reg       <= mode;
            end
        end
    end

`ifdef COUNT_SEQ_WRAP_EN
    logic [7:0] laps_reg;
    logic       lap;

    assign lap = (state_reg == RUN) && !stop && terminal;

    // Lap counter: cleared on a new run, saturating at 255.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            laps_reg <= '0;
        end else if (capture) begin
            laps_reg <= '0;
        end else if (lap && (laps_reg != 8'hFF)) begin
            laps_reg <= laps_reg + 8'd1;
        end
    end

    assign laps = laps_reg;
`else
    assign laps = '0;
`endif

    assign cnt_load   = (state_reg == LOAD);
    assign busy       = (state_reg == LOAD) || (state_reg == RUN);
    assign done       = (state_reg == DONE);
    assign state      = state_reg;
    assign load_value = load_value_reg;

endmodule
